rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the 64-bit 2:1 datapath mux. It lets several producers share one consumer port, e.g. the I-fetch and D-memory requests onto one memory bus, or multiple writeback sources onto one register-file write port. Selection is made by a round-robin arbiter instead of an external enable, and the result is held in a one-entry output register.

## Interface
- `WIDTH`, 64: data width per channel.
- `N`, 4: number of input channels. Legal range is 2..16.
- `SELW`, `$clog2(N)`: width of the select index. Derived; never override.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input N: bit i means channel i presents data.
- `in_ready` output N: bit i means channel i is accepted this cycle.
- `in_data` input N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `out_valid` output 1: the output register holds a word.
- `out_ready` input 1: the consumer takes the word this cycle.
- `out_data` output WIDTH: the registered word.
- `out_sel` output SELW: the channel index that produced `out_data`.

## Operation
- **Transfer rule.** A transfer on any side occurs when valid and ready are both high at a rising edge.
- **Output register states.** The register has two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY → FULL: any grant.
  - FULL → EMPTY: `out_ready`=1 with no new grant.
  - FULL → FULL: `out_ready`=1 with a grant (replace), or `out_ready`=0 (hold).
- **Load enable.** `load = !out_valid || out_ready`.
- **Arbiter.** The arbiter holds a round-robin pointer `rr_ptr` (SELW bits).
  - Priority order is `rr_ptr`, `rr_ptr+1`, …, `N-1`, `0`, …, `rr_ptr-1`, wrapping modulo N.
  - The grant is one-hot. It goes to the first channel in priority order with `in_valid` set.
- **Ready generation.** `in_ready[i] = grant[i] && load`.
  - At most one `in_ready` bit is high in any cycle.
  - `in_ready` is zero when no channel is valid.
- **Accepted transfer.** On a transfer from channel g:
  - `out_data` ← the data of channel g.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `rr_ptr` ← (g+1) mod N. When g = N-1 the pointer wraps to 0.
- **Pointer hold.** `rr_ptr` does not change in cycles with no transfer, including stalled cycles where valid is high but `load`=0.
- **Producer rules.** A producer must not make `in_valid` depend on `in_ready`. It must hold `in_valid` and its data stable until accepted.
- **Output stability.** While FULL and `out_ready`=0, `out_data` and `out_sel` are held unchanged.
- **Reset values.**
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `rr_ptr`=0.
  - `in_ready`=0 during the reset cycle.
- **Reset mid-operation.** A held word is discarded. No handshake completes in the reset cycle.

## Timing
- Latency is 1 cycle: data accepted at edge k is visible on `out_data` after edge k.
- Throughput is 1 word/cycle. Drain and load happen in the same cycle when FULL and `out_ready`=1.
- `in_ready` is combinational from `in_valid`, `rr_ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- Fairness: with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once every N cycles.

## Configuration
- Macro: `RR_MUX_FIXED_PRIO_EN`.
- **Defined:** fixed priority, where the lowest-index valid channel always wins. `rr_ptr` is not implemented and is treated as constant 0. The fairness guarantee does not apply.
- **Undefined (default):** round-robin arbitration as described in Operation.

## Structure
- The shared package `mux_pkg` holds:
  - default constants `MUX_WIDTH`=64 and `MUX_N`=4;
  - the state encoding `OUT_EMPTY`=0 and `OUT_FULL`=1.
- The top module contains the output register, the pointer and the handshake logic.
- One sub-module, `rr_arbiter`, is natural. It is purely combinational, maps (`req`[N], `ptr`) to `grant`[N] (one-hot) and `grant_idx`[SELW], and is reusable elsewhere.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `in_ready`=0, `out_data`=0. The first grant after release goes to channel 0.
- **Round-robin:** N=4, all channels valid with data 0x10+i, `out_ready`=1 → `out_sel` sequence 0,1,2,3,0 and `out_data` 0x10,0x11,0x12,0x13,0x10.
- **Backpressure:** fill with channel 2 = 0xDEAD, then set `out_ready`=0 for 5 cycles → `out_valid`=1 and `out_data`=0xDEAD held; `in_ready`=0 throughout; `rr_ptr` stays 3.
- **Wrap and skip:** only channels 3 and 1 valid, `rr_ptr`=3 → grants 3, then 1, then 3. Idle channels are never granted.
- **Simultaneous drain and load:** FULL, `out_ready`=1, channel 0 valid with 0x55 → the same-cycle handshake completes; `out_data`=0x55 next cycle with `out_valid` never dropping.
- **Fixed priority:** with `RR_MUX_FIXED_PRIO_EN` defined and channels 1 and 3 valid continuously → channel 1 is granted every cycle and channel 3 never.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the arbitrating output mux: default sizes and output-register state encoding.
package mux_pkg;

   localparam int unsigned MUX_WIDTH = 64;
   localparam int unsigned MUX_N     = 4;

   localparam logic [0:0] OUT_EMPTY = 1'b0;
   localparam logic [0:0] OUT_FULL  = 1'b1;

endpackage : mux_pkg

// File: rtl/rr_arb_mux_if.sv
// Producer/consumer bundle for rr_arb_mux: N valid/ready/data input channels and one registered output.
interface rr_arb_mux_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 4
);
   localparam int unsigned SELW = $clog2(N);

   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;

   // Environment side: drives producers and the consumer ready.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   // Mux side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface : rr_arb_mux_if

// File: rtl/rr_arb_mux_arbiter.sv
// rr_arbiter: purely combinational rotating-priority arbiter. Search starts at ptr_i and wraps
// modulo N; the first requesting channel gets a one-hot grant plus its binary index.
module rr_arbiter #(
   parameter int unsigned N    = 4,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [SELW-1:0] ptr_i,
   output logic [N-1:0]    grant_o,
   output logic [SELW-1:0] grant_idx_o
);

   logic found;

   // Walk channels in priority order, latching the first requester.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         automatic logic [SELW-1:0] idx = SELW'((32'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
            found        = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbitrating mux with a one-entry registered output stage.
// Build option RR_MUX_FIXED_PRIO_EN: lowest-index valid channel always wins (no rotating pointer).
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = MUX_WIDTH,
   parameter int unsigned N     = MUX_N,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   rr_arb_mux_if.slave  bus
);

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [SELW-1:0]  arb_ptr;
   logic [N-1:0]     grant;
   logic [SELW-1:0]  grant_idx;
   logic             load;
   logic             xfer;

`ifdef RR_MUX_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
   assign arb_ptr = rr_ptr_q;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .req_i       (bus.in_valid),
      .ptr_i       (arb_ptr),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Handshake: the register can accept when empty or being drained; nothing completes during reset.
   assign load          = (state_q == OUT_EMPTY) || bus.out_ready;
   assign xfer          = load && (|bus.in_valid) && !rst;
   assign bus.in_ready  = (load && !rst) ? grant : '0;
   assign bus.out_valid = (state_q == OUT_FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
`ifndef RR_MUX_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         OUT_EMPTY: if (xfer) state_d = OUT_FULL;
         OUT_FULL:  if (bus.out_ready && !xfer) state_d = OUT_EMPTY;
         default:   state_d = OUT_EMPTY;
      endcase
      if (xfer) begin
         data_d = bus.in_data[32'(grant_idx)*WIDTH +: WIDTH];
         sel_d  = grant_idx;
`ifndef RR_MUX_FIXED_PRIO_EN
         rr_ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
`endif
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OUT_EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
`ifndef RR_MUX_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

endmodule : rr_arb_mux

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: directed stimulus, a per-cycle reference model and hand-computed expectations.
module tb_rr_arb_mux;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned N     = 4;
   localparam int unsigned SELW  = $clog2(N);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   rr_arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

   rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int unsigned ch, input logic [WIDTH-1:0] v);
      bus.in_data[ch*WIDTH +: WIDTH] = v;
   endtask

   // Reference model: what the consumer side must hold, and where the rotating priority starts.
   bit              m_full = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   int unsigned     m_sel = 0;
   int unsigned     m_ptr = 0;

   // Compare every cycle on the falling edge, then advance the model to the next rising edge.
   always @(negedge clk) begin
      automatic int   win = -1;
      automatic logic [N-1:0] exp_rdy = '0;
      automatic bit   can_take = !m_full || (bus.out_ready === 1'b1);
      for (int k = 0; k < int'(N); k++) begin
         automatic int unsigned c = (m_ptr + k) % N;
         if (win < 0 && bus.in_valid[c] === 1'b1) win = int'(c);
      end
      if (!rst && can_take && win >= 0) exp_rdy[win] = 1'b1;
      if (chk_en) begin
         chk("cyc_in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         chk("cyc_out_valid", 64'(bus.out_valid), 64'(m_full));
         if (m_full) begin
            chk("cyc_out_data", bus.out_data, m_data);
            chk("cyc_out_sel", 64'(bus.out_sel), 64'(m_sel));
         end
      end
      if (rst) begin
         m_full = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (exp_rdy != '0) begin
         m_full = 1'b1;
         m_data = bus.in_data[win*WIDTH +: WIDTH];
         m_sel  = win;
`ifdef RR_MUX_FIXED_PRIO_EN
         m_ptr  = 0;
`else
         m_ptr  = (win + 1) % N;
`endif
      end else if (m_full && bus.out_ready === 1'b1) begin
         m_full = 1'b0;
      end
   end

   initial begin
      int seq[5] = '{0, 1, 2, 3, 0};
      bus.in_valid  = '1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < int'(N); i++) set_data(i, 64'(32'h10 + i));

      // Reset held two cycles with every channel valid.
      @(posedge clk);
      #1 chk_en = 1'b1;
      step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", bus.out_data, 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      #1 chk("first_grant", 64'(bus.in_ready), 64'b0001);

`ifndef RR_MUX_FIXED_PRIO_EN
      // Round-robin across all channels.
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_sel", 64'(bus.out_sel), 64'(seq[i]));
         chk("rr_data", bus.out_data, 64'(32'h10 + seq[i]));
      end

      // Backpressure: load channel 2, then stall five cycles.
      bus.in_valid = 4'b0100;
      set_data(2, 64'hDEAD);
      #1 chk("bp_load_rdy", 64'(bus.in_ready), 64'b0100);
      step();
      chk("bp_load_data", bus.out_data, 64'hDEAD);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         step();
         chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold_data", bus.out_data, 64'hDEAD);
      end
      bus.out_ready = 1'b1;
      #1 chk("bp_ptr_held", 64'(bus.in_ready), 64'b1000);

      // Wrap and skip: only channels 3 and 1 valid, pointer at 3.
      bus.in_valid = 4'b1010;
      #1 chk("wrap_rdy3", 64'(bus.in_ready), 64'b1000);
      step();
      chk("wrap_sel3", 64'(bus.out_sel), 64'd3);
      chk("wrap_data3", bus.out_data, 64'h13);
      chk("wrap_rdy1", 64'(bus.in_ready), 64'b0010);
      step();
      chk("wrap_sel1", 64'(bus.out_sel), 64'd1);
      chk("wrap_data1", bus.out_data, 64'h11);
      step();
      chk("wrap_sel3b", 64'(bus.out_sel), 64'd3);
`endif

      // Simultaneous drain and load.
      bus.in_valid = 4'b0001;
      set_data(0, 64'h55);
      #1 chk("dl_rdy", 64'(bus.in_ready), 64'b0001);
      step();
      chk("dl_valid", 64'(bus.out_valid), 64'd1);
      chk("dl_data", bus.out_data, 64'h55);
      bus.in_valid = '0;
      #1 chk("idle_rdy", 64'(bus.in_ready), 64'd0);
      step();
      chk("drain_valid", 64'(bus.out_valid), 64'd0);

      // Reset while holding a word.
      bus.in_valid = 4'b0001;
      step();
      rst = 1'b1;
      #1 chk("midrst_rdy", 64'(bus.in_ready), 64'd0);
      step();
      chk("midrst_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_data", bus.out_data, 64'd0);
      rst = 1'b0;

      // Channels 1 and 3 continuously valid from pointer 0.
      bus.in_valid = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         step();
`ifdef RR_MUX_FIXED_PRIO_EN
         chk("alt_sel", 64'(bus.out_sel), 64'd1);
`else
         chk("alt_sel", 64'(bus.out_sel), (i % 2 == 0) ? 64'd1 : 64'd3);
`endif
      end
      bus.in_valid = '0;
      step();
      step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rr_arb_mux
